// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the BCD stopwatch.
//   state_e    - FSM encoding (STOP/RUN/LAP)
//   bcd_time_t - MM:SS as four packed BCD digits, tens-of-minutes first
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] LIM_9 = 4'd9;
    localparam logic [DIGIT_W-1:0] LIM_5 = 4'd5;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_hi;
        logic [DIGIT_W-1:0] min_lo;
        logic [DIGIT_W-1:0] sec_hi;
        logic [DIGIT_W-1:0] sec_lo;
    } bcd_time_t;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one mod-(lim+1) BCD digit of the stopwatch chain.
//   clk, rst - system clock, async active-high reset
//   clr      - synchronous clear, wins over en
//   en       - advance by one this cycle
//   lim      - highest value before wrapping to 0
//   q        - registered digit value
//   nxt      - value q will take after the next edge (used for same-cycle snapshots)
//   co       - carry out, en & (q == lim); feeds the next digit's en combinationally
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [DIGIT_W-1:0] lim,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] nxt,
    output logic               co
);

    logic [DIGIT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == lim) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q   = q_q;
    assign nxt = q_d;
    assign co  = en & (q_q == lim);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD MM:SS stopwatch driven by the divider's clk_out level.
//   clk, rst        - system clock, async active-high reset
//   tick_in         - divider output level; each rising edge is one second
//   start/stop/lap/clear - single-cycle command pulses (clear > stop > start > lap)
//   running         - high in RUN and LAP
//   lap_hold        - high in LAP (display frozen on snapshot)
//   sec_lo..min_hi  - displayed BCD digits
//   wrap            - one-cycle pulse when the live count rolls over to 00:00
// Every output comes from a flop, or from a mux of flops selected by a flop.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MIN_HI = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic               start,
    input  logic               stop,
    input  logic               lap,
    input  logic               clear,
    output logic               running,
    output logic               lap_hold,
    output logic [DIGIT_W-1:0] sec_lo,
    output logic [DIGIT_W-1:0] sec_hi,
    output logic [DIGIT_W-1:0] min_lo,
    output logic [DIGIT_W-1:0] min_hi,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] MIN_HI_LIM = DIGIT_W'(MAX_MIN_HI);

    state_e    state_q, state_d;
    logic      s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    bcd_time_t snap_q, snap_d;
    logic      running_q, running_d;
    logic      lap_hold_q, lap_hold_d;
    logic      wrap_q, wrap_d;

    logic      inc;
    logic      co_sl, co_sh, co_ml, co_mh;
    bcd_time_t live, live_nxt;

    // s1/s2 synchronize, s3 remembers last level for rising-edge detect.
    always_comb begin
        s1_d = tick_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Gate on the current state so a tick coinciding with stop still counts.
    assign inc = s2_q & ~s3_q & (state_q != ST_STOP);

    bcd_digit u_sec_lo (.clk(clk), .rst(rst), .clr(clear), .en(inc),   .lim(LIM_9),
                        .q(live.sec_lo), .nxt(live_nxt.sec_lo), .co(co_sl));
    bcd_digit u_sec_hi (.clk(clk), .rst(rst), .clr(clear), .en(co_sl), .lim(LIM_5),
                        .q(live.sec_hi), .nxt(live_nxt.sec_hi), .co(co_sh));
    bcd_digit u_min_lo (.clk(clk), .rst(rst), .clr(clear), .en(co_sh), .lim(LIM_9),
                        .q(live.min_lo), .nxt(live_nxt.min_lo), .co(co_ml));
    bcd_digit u_min_hi (.clk(clk), .rst(rst), .clr(clear), .en(co_ml), .lim(MIN_HI_LIM),
                        .q(live.min_hi), .nxt(live_nxt.min_hi), .co(co_mh));

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        if (clear) begin
            state_d = ST_STOP;
            snap_d  = '0;
        end else if (stop) begin
            if (state_q != ST_STOP) state_d = ST_STOP;
        end else if (start) begin
            if (state_q == ST_STOP) state_d = ST_RUN;
        end else if (lap) begin
            if (state_q == ST_RUN) begin
                state_d = ST_LAP;
                // Post-increment value, so a tick in the entry cycle is included.
                snap_d  = live_nxt;
            end else if (state_q == ST_LAP) begin
                state_d = ST_RUN;
            end
        end
        running_d  = (state_d != ST_STOP);
        lap_hold_d = (state_d == ST_LAP);
        // Clear zeroes the chain in the same cycle, so the rollover never shows.
        wrap_d     = co_mh & ~clear;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_STOP;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            snap_q     <= '0;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            snap_q     <= snap_d;
            running_q  <= running_d;
            lap_hold_q <= lap_hold_d;
            wrap_q     <= wrap_d;
        end
    end

    assign running  = running_q;
    assign lap_hold = lap_hold_q;
    assign wrap     = wrap_q;

    always_comb begin
        if (lap_hold_q) {min_hi, min_lo, sec_hi, sec_lo} = snap_q;
        else            {min_hi, min_lo, sec_hi, sec_lo} = live;
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core. Inputs change on the falling clock
// edge; outputs are sampled on the falling edge as well.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_in = 1'b0;
    logic       start = 1'b0, stop = 1'b0, lap = 1'b0, clear = 1'b0;
    logic       running, lap_hold, wrap;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi;

    int checks = 0;
    int errors = 0;

    stopwatch_core #(.MAX_MIN_HI(5)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in),
        .start(start), .stop(stop), .lap(lap), .clear(clear),
        .running(running), .lap_hold(lap_hold),
        .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] disp();
        return {min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    task automatic tick(input int hi, input int lo);
        @(negedge clk) tick_in = 1'b1;
        repeat (hi) @(negedge clk);
        tick_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(4, 4);
    endtask

    // {start, stop, lap, clear} held for exactly one sampling edge.
    task automatic cmd(input logic [3:0] c);
        @(negedge clk) {start, stop, lap, clear} = c;
        @(negedge clk) {start, stop, lap, clear} = 4'b0000;
    endtask

    localparam logic [3:0] C_START = 4'b1000, C_STOP = 4'b0100,
                           C_LAP = 4'b0010, C_CLEAR = 4'b0001;

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({running, lap_hold, wrap} !== 3'b000 || disp() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got r=%b l=%b w=%b %h exp 0 0 0 0000",
                     running, lap_hold, wrap, disp());
        end
        rst = 1'b0;
        ticks(2);
        checks++;
        if (disp() !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL stop_after_reset: got %h r=%b exp 0000 r=0", disp(), running);
        end
    endtask

    task automatic test_basic_count();
        cmd(C_START);
        checks++;
        if (running !== 1'b1 || lap_hold !== 1'b0) begin
            errors++;
            $display("FAIL start_running: got r=%b l=%b exp 1 0", running, lap_hold);
        end
        // First tick: observe the two-edge latency.
        @(negedge clk) tick_in = 1'b1;
        @(negedge clk);               // after edge k
        checks++;
        if (disp() !== 16'h0000) begin
            errors++;
            $display("FAIL latency_k: got %h exp 0000", disp());
        end
        @(negedge clk);               // after edge k+1
        checks++;
        if (disp() !== 16'h0000) begin
            errors++;
            $display("FAIL latency_k1: got %h exp 0000", disp());
        end
        @(negedge clk);               // after edge k+2
        checks++;
        if (disp() !== 16'h0001) begin
            errors++;
            $display("FAIL latency_k2: got %h exp 0001", disp());
        end
        @(negedge clk) tick_in = 1'b0;
        repeat (4) @(negedge clk);
        ticks(9);
        checks++;
        if (disp() !== 16'h0010 || running !== 1'b1) begin
            errors++;
            $display("FAIL basic_10: got %h r=%b exp 0010 r=1", disp(), running);
        end
    endtask

    task automatic test_stop_discard();
        cmd(C_CLEAR);
        cmd(C_START);
        ticks(3);
        cmd(C_STOP);
        ticks(5);
        checks++;
        if (disp() !== 16'h0003 || running !== 1'b0) begin
            errors++;
            $display("FAIL stop_hold: got %h r=%b exp 0003 r=0", disp(), running);
        end
        cmd(C_START);
        ticks(1);
        checks++;
        if (disp() !== 16'h0004) begin
            errors++;
            $display("FAIL restart: got %h exp 0004", disp());
        end
    endtask

    task automatic test_lap();
        cmd(C_CLEAR);
        cmd(C_START);
        ticks(7);
        cmd(C_LAP);
        ticks(4);
        checks++;
        if (disp() !== 16'h0007 || lap_hold !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL lap_frozen: got %h l=%b r=%b exp 0007 1 1", disp(), lap_hold, running);
        end
        cmd(C_LAP);
        checks++;
        if (disp() !== 16'h0011 || lap_hold !== 1'b0) begin
            errors++;
            $display("FAIL lap_release: got %h l=%b exp 0011 0", disp(), lap_hold);
        end
        // Lap entry in the same cycle as inc: snapshot holds 00:12.
        @(negedge clk) tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk) lap = 1'b1;
        @(negedge clk) lap = 1'b0;
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        ticks(1);
        checks++;
        if (disp() !== 16'h0012 || lap_hold !== 1'b1) begin
            errors++;
            $display("FAIL lap_inc_snapshot: got %h l=%b exp 0012 1", disp(), lap_hold);
        end
        cmd(C_STOP);
        checks++;
        if (disp() !== 16'h0013 || lap_hold !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL lap_stop_live: got %h l=%b r=%b exp 0013 0 0", disp(), lap_hold, running);
        end
    endtask

    task automatic test_priority();
        cmd(C_CLEAR);
        cmd(C_START);
        ticks(2);
        cmd(C_CLEAR | C_START);
        checks++;
        if (disp() !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL clear_start: got %h r=%b exp 0000 r=0", disp(), running);
        end
        cmd(C_STOP | C_START);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL stop_start_idle: got r=%b exp 0", running);
        end
        cmd(C_START);
        cmd(C_STOP | C_START);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL stop_start_run: got r=%b exp 0", running);
        end
        cmd(C_START | C_LAP);
        checks++;
        if (running !== 1'b1 || lap_hold !== 1'b0) begin
            errors++;
            $display("FAIL start_lap: got r=%b l=%b exp 1 0", running, lap_hold);
        end
        // Tick edge coincident with stop: counts once.
        @(negedge clk) tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        tick_in = 1'b0;
        checks++;
        if (disp() !== 16'h0001 || running !== 1'b0) begin
            errors++;
            $display("FAIL stop_with_inc: got %h r=%b exp 0001 r=0", disp(), running);
        end
        repeat (3) @(negedge clk);
        // Tick edge coincident with clear: count ends at 0.
        cmd(C_START);
        @(negedge clk) tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        tick_in = 1'b0;
        checks++;
        if (disp() !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clear_with_inc: got %h r=%b w=%b exp 0000 0 0", disp(), running, wrap);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rollover();
        int wrap_cnt;
        cmd(C_CLEAR);
        cmd(C_START);
        for (int i = 0; i < 3599; i++) tick(2, 2);
        checks++;
        if (disp() !== 16'h5959 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL preload_5959: got %h w=%b exp 5959 0", disp(), wrap);
        end
        wrap_cnt = 0;
        @(negedge clk) tick_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) tick_in = 1'b0;
            if (wrap === 1'b1) begin
                wrap_cnt++;
                checks++;
                if (disp() !== 16'h0000) begin
                    errors++;
                    $display("FAIL wrap_digits: got %h exp 0000", disp());
                end
            end
        end
        checks++;
        if (wrap_cnt != 1 || disp() !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_pulse: got %0d cycles %h exp 1 cycle 0000", wrap_cnt, disp());
        end
        ticks(1);
        checks++;
        if (disp() !== 16'h0001) begin
            errors++;
            $display("FAIL after_wrap: got %h exp 0001", disp());
        end
    endtask

    task automatic test_async_reset();
        cmd(C_LAP);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({running, lap_hold, wrap} !== 3'b000 || disp() !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got r=%b l=%b w=%b %h exp 0 0 0 0000",
                     running, lap_hold, wrap, disp());
        end
        @(negedge clk) rst = 1'b0;
        ticks(2);
        checks++;
        if (disp() !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h r=%b exp 0000 r=0", disp(), running);
        end
        cmd(C_START);
        ticks(1);
        checks++;
        if (disp() !== 16'h0001 || running !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_run: got %h r=%b exp 0001 r=1", disp(), running);
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_stop_discard();
        test_lap();
        test_priority();
        test_rollover();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
